// File: rtl/square_move.sv
// square_move: falling-piece motion controller.
// Owns the anchor and sequences spawn, fall, lock and game over.
module square_move #(
  parameter int SPAWN_COL = 8,
  parameter int TICK_DIV  = 25_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         move_l,
  input  logic         move_r,
  input  logic         move_d,
  input  logic         rotate_r,
  input  logic [15:0]  enable_moving,
  input  logic [499:0] enable_little,
  input  logic         board_done,
  output logic [8:0]   little_square_num,
  output logic         loading_square,
  output logic         lock_piece,
  output logic         game_over
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);
  localparam logic [4:0] SCOL = 5'(SPAWN_COL);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_LOAD, S_CHECK,
    S_FALL, S_LOCK, S_WAIT, S_OVER
  } state_t;

  state_t        st_q, st_d;
  logic [4:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    num_q, num_d;
  logic          rot_q, rot_d;
  logic          load_q, load_d;
  logic          lock_q, lock_d;
  logic          over_q, over_d;
  logic          spawn, tick, guard;
  logic          fit_sp, fit_dn, fit_l, fit_r;

  // Out-of-window cells (row > 24 or col > 19) count as occupied.
  function automatic logic fits(
    input logic [15:0]  m,
    input logic [499:0] b,
    input logic [5:0]   r,
    input logic [5:0]   c
  );
    logic       ok;
    logic [5:0] rr, cc;
    logic [8:0] idx;
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rr  = r + 6'(k / 4);
      cc  = c + 6'(k % 4);
      idx = 9'(rr) * 9'd20 + 9'(cc);
      if (m[k] && (rr > 6'd24 || cc > 6'd19 || b[idx]))
        ok = 1'b0;
    end
    return ok;
  endfunction

  assign fit_sp = fits(enable_moving, enable_little,
                       6'd0, {1'b0, SCOL});
  assign fit_dn = fits(enable_moving, enable_little,
                       {1'b0, row_q} + 6'd1, {1'b0, col_q});
  assign fit_l  = fits(enable_moving, enable_little,
                       {1'b0, row_q}, {1'b0, col_q} - 6'd1);
  assign fit_r  = fits(enable_moving, enable_little,
                       {1'b0, row_q}, {1'b0, col_q} + 6'd1);

  always_comb begin
    st_d   = st_q;
    row_d  = row_q;
    col_d  = col_q;
    cnt_d  = cnt_q;
    over_d = over_q;
    load_d = 1'b0;
    lock_d = 1'b0;
    spawn  = 1'b0;
    rot_d  = rotate_r;
    tick   = (cnt_q == TMAX);
    guard  = rotate_r | rot_q;
    unique case (st_q)
      S_IDLE:  spawn = start;
      S_SPAWN: st_d = S_LOAD;
      S_LOAD:  st_d = S_CHECK;
      S_CHECK: begin
        if (fit_sp) begin
          st_d  = S_FALL;
          cnt_d = '0;
        end else begin
          st_d   = S_OVER;
          over_d = 1'b1;
        end
      end
      S_FALL: begin
        // Guard freezes the anchor; a due tick waits at TMAX.
        if (guard) begin
          if (!tick) cnt_d = cnt_q + 1'b1;
        end else if (tick | move_d) begin
          if (fit_dn) begin
            row_d = row_q + 1'b1;
            cnt_d = '0;
          end else begin
            st_d   = S_LOCK;
            lock_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (move_l & ~move_r & (col_q != 5'd0) & fit_l)
            col_d = col_q - 1'b1;
          else if (move_r & ~move_l & fit_r)
            col_d = col_q + 1'b1;
        end
      end
      S_LOCK:  st_d = S_WAIT;
      S_WAIT:  spawn = board_done;
      S_OVER: begin
        spawn = start;
        if (start) over_d = 1'b0;
      end
    endcase
    if (spawn) begin
      st_d   = S_SPAWN;
      row_d  = 5'd0;
      col_d  = SCOL;
      load_d = 1'b1;
    end
    num_d = 9'(row_d) * 9'd20 + 9'(col_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      row_q  <= 5'd0;
      col_q  <= SCOL;
      cnt_q  <= '0;
      num_q  <= 9'(SPAWN_COL);
      rot_q  <= 1'b0;
      load_q <= 1'b0;
      lock_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      row_q  <= row_d;
      col_q  <= col_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      rot_q  <= rot_d;
      load_q <= load_d;
      lock_q <= lock_d;
      over_q <= over_d;
    end
  end

  assign little_square_num = num_q;
  assign loading_square    = load_q;
  assign lock_piece        = lock_q;
  assign game_over         = over_q;

endmodule

// File: tb/tb_square_move.sv
// tb_square_move: directed and random checks of square_move
// against a rule-level model of the piece controller.
module tb_square_move;

  localparam int SC = 8;
  localparam int TD = 4;

  logic         clk, rst_n, start;
  logic         move_l, move_r, move_d, rotate_r;
  logic [15:0]  mask;
  logic [499:0] board;
  logic         board_done;
  logic [8:0]   num;
  logic         loading, lock, over;

  int n_checks = 0;
  int n_fail   = 0;

  square_move #(.SPAWN_COL(SC), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .move_l(move_l), .move_r(move_r), .move_d(move_d),
    .rotate_r(rotate_r), .enable_moving(mask),
    .enable_little(board), .board_done(board_done),
    .little_square_num(num), .loading_square(loading),
    .lock_piece(lock), .game_over(over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {PH_IDLE, PH_SPAWN, PH_LOAD, PH_CHECK,
                PH_FALL, PH_LOCK, PH_WAIT, PH_OVER} ph_t;
  ph_t m_ph;
  int  m_row, m_col, m_cnt;
  bit  m_rotp, m_load, m_lock, m_over;

  function automatic bit m_fits(int r, int c);
    for (int k = 0; k < 16; k++) begin
      if (mask[k]) begin
        int rr = r + k / 4;
        int cc = c + k % 4;
        if (rr > 24 || cc > 19 || cc < 0) return 1'b0;
        if (board[rr * 20 + cc]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic int m_num();
    return m_row * 20 + m_col;
  endfunction

  task automatic m_reset();
    m_ph = PH_IDLE; m_row = 0; m_col = SC; m_cnt = 0;
    m_rotp = 0; m_load = 0; m_lock = 0; m_over = 0;
  endtask

  task automatic m_spawn();
    m_ph = PH_SPAWN; m_row = 0; m_col = SC; m_load = 1;
  endtask

  task automatic m_step();
    bit g, tk;
    g = rotate_r || m_rotp;
    m_rotp = rotate_r;
    m_load = 0;
    m_lock = 0;
    case (m_ph)
      PH_IDLE:  if (start) m_spawn();
      PH_SPAWN: m_ph = PH_LOAD;
      PH_LOAD:  m_ph = PH_CHECK;
      PH_CHECK: begin
        if (m_fits(0, SC)) begin m_ph = PH_FALL; m_cnt = 0; end
        else begin m_ph = PH_OVER; m_over = 1; end
      end
      PH_FALL: begin
        tk = (m_cnt == TD - 1);
        if (g) begin
          if (!tk) m_cnt++;
        end else if (tk || move_d) begin
          if (m_fits(m_row + 1, m_col)) begin m_row++; m_cnt = 0; end
          else begin m_ph = PH_LOCK; m_lock = 1; end
        end else begin
          m_cnt++;
          if (move_l && !move_r && m_col > 0 && m_fits(m_row, m_col - 1))
            m_col--;
          else if (move_r && !move_l && m_fits(m_row, m_col + 1))
            m_col++;
        end
      end
      PH_LOCK: m_ph = PH_WAIT;
      PH_WAIT: if (board_done) m_spawn();
      PH_OVER: if (start) begin m_over = 0; m_spawn(); end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic clear_in();
    start = 0; move_l = 0; move_r = 0; move_d = 0;
    rotate_r = 0; board_done = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 0;
    @(posedge clk);
    #1;
    m_reset();
    rst_n = 1;
  endtask

  task automatic begin_game();
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    board = '0; mask = 16'h0660;
    do_reset();
    n_checks++;
    if (num !== 9'd8) begin
      n_fail++; $display("FAIL reset_num got=%0d exp=8", num);
    end
    n_checks++;
    if ({loading, lock, over} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {loading, lock, over});
    end
  endtask

  task automatic test_start_lateral();
    board = '0; mask = 16'h0660;
    do_reset();
    start = 1; cyc(); start = 0;
    n_checks++;
    if (loading !== 1'b1 || num !== 9'd8) begin
      n_fail++; $display("FAIL start_load got=%b/%0d exp=1/8", loading, num);
    end
    cyc();
    n_checks++;
    if (loading !== 1'b0) begin
      n_fail++; $display("FAIL load_pulse got=%b exp=0", loading);
    end
    cyc(); cyc();
    move_r = 1; cyc(); move_r = 0;
    n_checks++;
    if (num !== 9'd9) begin
      n_fail++; $display("FAIL move_r got=%0d exp=9", num);
    end
    move_l = 1; cyc(); move_l = 0;
    n_checks++;
    if (num !== 9'd8) begin
      n_fail++; $display("FAIL move_l got=%0d exp=8", num);
    end
  endtask

  task automatic test_gravity_lock();
    board = '0; mask = 16'h0660;
    begin_game();
    for (int i = 1; i <= 22; i++) begin
      repeat (4) cyc();
      n_checks++;
      if (num !== 9'(8 + 20 * i)) begin
        n_fail++; $display("FAIL gravity row%0d got=%0d exp=%0d", i, num, 8 + 20 * i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (lock !== (i == 3) || num !== 9'd448) begin
        n_fail++; $display("FAIL lock_cyc%0d got=%b/%0d exp=%b/448", i, lock, num, i == 3);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++;
      if (loading !== 1'b0 || lock !== 1'b0) begin
        n_fail++; $display("FAIL wait_board%0d got=%b%b exp=00", i, loading, lock);
      end
    end
    board_done = 1; cyc(); board_done = 0;
    n_checks++;
    if (loading !== 1'b1 || num !== 9'd8) begin
      n_fail++; $display("FAIL board_done got=%b/%0d exp=1/8", loading, num);
    end
    board = '0;
    for (int i = 480; i < 500; i++) board[i] = 1'b1;
    begin_game();
    for (int n = 0; n < 200 && lock !== 1'b1; n++) cyc();
    n_checks++;
    if (lock !== 1'b1 || num !== 9'd428) begin
      n_fail++; $display("FAIL floor_lock got=%b/%0d exp=1/428", lock, num);
    end
  endtask

  task automatic test_left_edge();
    int exp;
    board = '0; mask = 16'h0033;
    begin_game();
    move_l = 1;
    for (int n = 0; n < 60 && m_col != 0; n++) cyc();
    move_l = 0;
    n_checks++;
    if (num !== 9'(m_row * 20)) begin
      n_fail++; $display("FAIL reach_col0 got=%0d exp=%0d", num, m_row * 20);
    end
    for (int n = 0; n < 8 && m_cnt == TD - 1; n++) cyc();
    exp = m_row * 20;
    move_l = 1; cyc(); move_l = 0;
    n_checks++;
    if (num !== 9'(exp)) begin
      n_fail++; $display("FAIL edge_left got=%0d exp=%0d", num, exp);
    end
    for (int n = 0; n < 8 && m_cnt == TD - 1; n++) cyc();
    exp = m_row * 20;
    move_l = 1; move_r = 1; cyc(); move_l = 0; move_r = 0;
    n_checks++;
    if (num !== 9'(exp)) begin
      n_fail++; $display("FAIL both_lr got=%0d exp=%0d", num, exp);
    end
  endtask

  task automatic test_tick_rotate();
    board = '0; mask = 16'h0660;
    begin_game();
    for (int n = 0; n < 8 && m_cnt != TD - 1; n++) cyc();
    move_r = 1; cyc(); move_r = 0;
    n_checks++;
    if (num !== 9'd28) begin
      n_fail++; $display("FAIL tick_vs_r got=%0d exp=28", num);
    end
    rotate_r = 1; cyc(); rotate_r = 0;
    move_l = 1; cyc(); move_l = 0;
    n_checks++;
    if (num !== 9'd28) begin
      n_fail++; $display("FAIL rot_guard got=%0d exp=28", num);
    end
    for (int n = 0; n < 8 && m_cnt != TD - 1; n++) cyc();
    rotate_r = 1; cyc(); rotate_r = 0;
    cyc();
    n_checks++;
    if (num !== 9'd28) begin
      n_fail++; $display("FAIL tick_defer got=%0d exp=28", num);
    end
    cyc();
    n_checks++;
    if (num !== 9'd48) begin
      n_fail++; $display("FAIL tick_resume got=%0d exp=48", num);
    end
  endtask

  task automatic test_over();
    board = '0; board[48] = 1; board[49] = 1;
    mask = 16'h0660;
    do_reset();
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    n_checks++;
    if (over !== 1'b0) begin
      n_fail++; $display("FAIL over_early got=%b exp=0", over);
    end
    cyc();
    n_checks++;
    if (over !== 1'b1) begin
      n_fail++; $display("FAIL over_set got=%b exp=1", over);
    end
    repeat (3) cyc();
    n_checks++;
    if (over !== 1'b1 || loading !== 1'b0) begin
      n_fail++; $display("FAIL over_hold got=%b%b exp=10", over, loading);
    end
    start = 1; cyc(); start = 0;
    n_checks++;
    if (over !== 1'b0 || loading !== 1'b1 || num !== 9'd8) begin
      n_fail++; $display("FAIL over_restart got=%b%b/%0d exp=01/8", over, loading, num);
    end
  endtask

  task automatic test_reset_midgame();
    board = '0; mask = 16'h0660;
    begin_game();
    move_r = 1; cyc(); move_r = 0;
    move_d = 1; cyc(); move_d = 0;
    #1 rst_n = 0;
    #2;
    n_checks++;
    if (num !== 9'd8 || {loading, lock, over} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset got=%0d/%b exp=8/000", num, {loading, lock, over});
    end
    @(posedge clk);
    #1;
    m_reset();
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [15:0] shapes [7];
    shapes = '{16'h0660, 16'h00f0, 16'h0072, 16'h0036,
               16'h0063, 16'h0071, 16'h0074};
    board = '0;
    for (int i = 200; i < 500; i++) board[i] = ($urandom_range(0, 3) == 0);
    mask = shapes[0];
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom_range(0, 7) == 0);
      move_l     = ($urandom_range(0, 2) == 0);
      move_r     = ($urandom_range(0, 2) == 0);
      move_d     = ($urandom_range(0, 5) == 0);
      rotate_r   = ($urandom_range(0, 9) == 0);
      board_done = ($urandom_range(0, 3) == 0);
      if (loading) mask = shapes[$urandom_range(0, 6)];
      if (n % 500 == 499)
        for (int i = 200; i < 500; i++)
          board[i] = ($urandom_range(0, 3) == 0);
      cyc();
      n_checks++;
      if ({num, loading, lock, over} !==
          {9'(m_num()), m_load, m_lock, m_over}) begin
        n_fail++;
        $display("FAIL random cyc%0d got=%0d/%b%b%b exp=%0d/%b%b%b",
                 n, num, loading, lock, over,
                 m_num(), m_load, m_lock, m_over);
      end
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    rst_n = 1;
    board = '0;
    mask = '0;
    m_reset();
    test_reset();
    test_start_lateral();
    test_gravity_lock();
    test_left_edge();
    test_tick_rotate();
    test_over();
    test_reset_midgame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
